// File: rtl/pcpu_pkg.sv
// Shared PCPU types: ALU op codes, operand selects, ID/EX bundle.
// Forwarding is built in only when ID_EX_FORWARD_EN is defined.
package pcpu_pkg;

    localparam int PCPU_XLEN   = 32;
    localparam int PCPU_REG_AW = 5;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_PASSB = 4'b1110;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2
    } src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } src_b_e;

    typedef struct packed {
        logic                   valid;
        logic [PCPU_XLEN-1:0]   pc;
        logic [PCPU_XLEN-1:0]   rs1_data;
        logic [PCPU_XLEN-1:0]   rs2_data;
        logic [PCPU_XLEN-1:0]   imm;
        logic [PCPU_REG_AW-1:0] rs1;
        logic [PCPU_REG_AW-1:0] rs2;
        logic [PCPU_REG_AW-1:0] rd;
        logic [3:0]             alu_ctrl;
        logic [1:0]             src_a;
        logic [1:0]             src_b;
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_write;
        logic                   mem_to_reg;
        logic                   branch;
        logic                   jump;
        logic [2:0]             funct3;
    } id_ex_t;

    // All-zero bubble; alu_ctrl zero is ALU_ADD.
    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forwarding select.
// EX/MEM beats MEM/WB; x0 never forwards.
module fwd_mux #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   rf_data,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_we,
    input  logic [XLEN-1:0]   exm_res,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    input  logic [XLEN-1:0]   wb_res,
    output logic [XLEN-1:0]   data
);

    logic exm_hit;
    logic wb_hit;

    assign exm_hit = exm_we && (exm_rd != '0) && (exm_rd == rs);
    assign wb_hit  = wb_we && (wb_rd != '0) && (wb_rd == rs);

    always_comb begin
        data = rf_data;
        if (exm_hit)
            data = exm_res;
        else if (wb_hit)
            data = wb_res;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX operand network and load-use detect.
// Define ID_EX_FORWARD_EN to build the EX/MEM and MEM/WB bypass.
module id_ex_stage
    import pcpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [3:0]        id_alu_ctrl_i,
    input  logic [1:0]        id_src_a_i,
    input  logic [1:0]        id_src_b_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic              id_mem_to_reg_i,
    input  logic              id_branch_i,
    input  logic              id_jump_i,
    input  logic [2:0]        id_funct3_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic              exm_reg_write_i,
    input  logic [XLEN-1:0]   exm_result_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_reg_write_i,
    input  logic [XLEN-1:0]   wb_result_i,
    output logic [XLEN-1:0]   alu_a_o,
    output logic [XLEN-1:0]   alu_b_o,
    output logic [3:0]        alu_ctrl_o,
    output logic [XLEN-1:0]   ex_store_data_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic              ex_valid_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic              ex_mem_to_reg_o,
    output logic              ex_branch_o,
    output logic              ex_jump_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [2:0]        ex_funct3_o,
    output logic              load_use_o
);

    id_ex_t nxt;
    id_ex_t r;

    always_comb begin
        nxt = ID_EX_BUBBLE;
        if (id_valid_i) begin
            nxt.valid      = 1'b1;
            nxt.pc         = id_pc_i;
            nxt.rs1_data   = id_rs1_data_i;
            nxt.rs2_data   = id_rs2_data_i;
            nxt.imm        = id_imm_i;
            nxt.rs1        = id_rs1_i;
            nxt.rs2        = id_rs2_i;
            nxt.rd         = id_rd_i;
            nxt.alu_ctrl   = id_alu_ctrl_i;
            nxt.src_a      = id_src_a_i;
            nxt.src_b      = id_src_b_i;
            nxt.reg_write  = id_reg_write_i;
            nxt.mem_read   = id_mem_read_i;
            nxt.mem_write  = id_mem_write_i;
            nxt.mem_to_reg = id_mem_to_reg_i;
            nxt.branch     = id_branch_i;
            nxt.jump       = id_jump_i;
            nxt.funct3     = id_funct3_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r <= ID_EX_BUBBLE;
        else if (flush_i)
            r <= ID_EX_BUBBLE;
        else if (!stall_i)
            r <= nxt;
    end

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

`ifdef ID_EX_FORWARD_EN
    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs      (r.rs1),
        .rf_data (r.rs1_data),
        .exm_rd  (exm_rd_i),
        .exm_we  (exm_reg_write_i),
        .exm_res (exm_result_i),
        .wb_rd   (wb_rd_i),
        .wb_we   (wb_reg_write_i),
        .wb_res  (wb_result_i),
        .data    (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs      (r.rs2),
        .rf_data (r.rs2_data),
        .exm_rd  (exm_rd_i),
        .exm_we  (exm_reg_write_i),
        .exm_res (exm_result_i),
        .wb_rd   (wb_rd_i),
        .wb_we   (wb_reg_write_i),
        .wb_res  (wb_result_i),
        .data    (rs2_fwd)
    );

    // Only a load in EX cannot be bypassed in time.
    assign load_use_o = r.valid && r.mem_read && (r.rd != '0) &&
                        id_valid_i &&
                        ((id_rs1_i == r.rd) || (id_rs2_i == r.rd));
`else
    logic unused_fwd;
    logic ex_hit;
    logic exm_hit;
    logic wb_hit;

    assign rs1_fwd    = r.rs1_data;
    assign rs2_fwd    = r.rs2_data;
    assign unused_fwd = ^{exm_result_i, wb_result_i, r.rs1, r.rs2};

    // Without bypass, any in-flight producer of a source must retire first.
    assign ex_hit  = r.valid && r.reg_write && (r.rd != '0) &&
                     ((id_rs1_i == r.rd) || (id_rs2_i == r.rd));
    assign exm_hit = exm_reg_write_i && (exm_rd_i != '0) &&
                     ((id_rs1_i == exm_rd_i) || (id_rs2_i == exm_rd_i));
    assign wb_hit  = wb_reg_write_i && (wb_rd_i != '0) &&
                     ((id_rs1_i == wb_rd_i) || (id_rs2_i == wb_rd_i));

    assign load_use_o = id_valid_i && (ex_hit || exm_hit || wb_hit);
`endif

    always_comb begin
        case (r.src_a)
            SRC_A_RS1:  alu_a_o = rs1_fwd;
            SRC_A_PC:   alu_a_o = r.pc;
            default:    alu_a_o = '0;
        endcase
    end

    always_comb begin
        case (r.src_b)
            SRC_B_RS2:  alu_b_o = rs2_fwd;
            SRC_B_IMM:  alu_b_o = r.imm;
            SRC_B_FOUR: alu_b_o = XLEN'(4);
            default:    alu_b_o = '0;
        endcase
    end

    assign alu_ctrl_o      = r.alu_ctrl;
    assign ex_store_data_o = rs2_fwd;
    assign ex_pc_o         = r.pc;
    assign ex_imm_o        = r.imm;
    assign ex_valid_o      = r.valid;
    assign ex_reg_write_o  = r.reg_write;
    assign ex_mem_read_o   = r.mem_read;
    assign ex_mem_write_o  = r.mem_write;
    assign ex_mem_to_reg_o = r.mem_to_reg;
    assign ex_branch_o     = r.branch;
    assign ex_jump_o       = r.jump;
    assign ex_rd_o         = r.rd;
    assign ex_funct3_o     = r.funct3;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus the EX-side operand network that feeds the 32-bit ALU (A, B, 4-bit control) in the 5-stage RISC-V PCPU.
- Registers decoded ID fields each cycle, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and flags load-use hazards to the hazard unit.
- Honours global stall (cache miss) and flush (branch/jump redirect).

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall_i  in  1  hold all stage registers
- flush_i  in  1  load bubble
- id_valid_i  in  1  ID slot holds an instruction
- id_pc_i  in  XLEN  instruction PC
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file reads
- id_imm_i  in  XLEN  sign-extended immediate
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW  register indices
- id_alu_ctrl_i  in  4  ALU op code
- id_src_a_i  in  2  A select: 0 rs1, 1 pc, 2 zero
- id_src_b_i  in  2  B select: 0 rs2, 1 imm, 2 const 4
- id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i, id_branch_i, id_jump_i  in  1  control
- id_funct3_i  in  3  branch/load/store width
- exm_rd_i  in  REG_AW; exm_reg_write_i  in  1; exm_result_i  in  XLEN  EX/MEM forward source
- wb_rd_i  in  REG_AW; wb_reg_write_i  in  1; wb_result_i  in  XLEN  MEM/WB forward source
- alu_a_o, alu_b_o  out  XLEN  ALU operands
- alu_ctrl_o  out  4  ALU control
- ex_store_data_o  out  XLEN  forwarded rs2 for stores
- ex_pc_o, ex_imm_o  out  XLEN  to branch-target adder
- ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_branch_o, ex_jump_o  out  1  registered control
- ex_rd_o  out  REG_AW; ex_funct3_o  out  3
- load_use_o  out  1  load-use hazard on current ID instruction

Behaviour:
- Register update on rising clk, priority: rst > flush_i > stall_i > load.
- rst and flush_i load bubble: valid=0, all write/read/branch/jump enables 0, rd=0, alu_ctrl=ADD (0000), data fields 0. Every registered output therefore resets to 0.
- flush_i and stall_i together: flush wins.
- stall_i alone: all registers hold; outputs stable.
- Load (neither asserted): capture all id_* fields. An invalid ID slot (id_valid_i=0) captures as bubble.
- Latency: one cycle, ID inputs to registered EX outputs.
- Forwarding is combinational from registered rs1/rs2, applied per operand:
  - Use exm_result_i if exm_reg_write_i and exm_rd_i!=0 and exm_rd_i==rs.
  - Otherwise use wb_result_i under the same rule.
  - Otherwise use the registered register-file data.
  - EX/MEM beats MEM/WB; x0 is never forwarded.
- alu_a_o = mux(src_a: fwd rs1 / pc / 0).
- alu_b_o = mux(src_b: fwd rs2 / imm / 32'd4). Select value 3 gives 0.
- ex_store_data_o is always forwarded rs2, independent of src_b.
- load_use_o (combinational) = ex_valid & ex_mem_read & ex_rd!=0 & id_valid_i & (id_rs1_i==ex_rd | id_rs2_i==ex_rd). Conservative: unused sources may cause a false stall.
- The hazard unit is expected to stall ID and drive flush_i into this stage for exactly one cycle. That inserts a single bubble.

Optional Feature:
- ID_EX_FORWARD_EN defined: forwarding as above.
- Undefined: the forward muxes are removed and the exm_*/wb_* inputs are ignored.
  - load_use_o widens to any RAW: matches ex_rd (ex_reg_write), exm_rd_i (exm_reg_write_i) or wb_rd_i (wb_reg_write_i), rd!=0, against id_rs1_i/id_rs2_i.
  - The hazard unit stalls until the producer retires.

Decomposition:
- Package pcpu_pkg holds:
  - ALU_ADD 0000, ALU_SUB 1000, ALU_AND 0111, ALU_OR 0110, ALU_XOR 0100, ALU_SLT 0010, ALU_SLTU 0011, ALU_SLL 0001, ALU_SRL 0101, ALU_SRA 1101, ALU_PASSB 1110.
  - SRC_A_* / SRC_B_* enums.
  - Typedef id_ex_t: packed struct of all registered fields.
- One sub-module, fwd_mux: single-operand forwarding select, instantiated twice.

Test Plan:
- rst held 2 cycles, then released with id_valid_i=0 -> all outputs 0, alu_ctrl_o=0000.
- Load add x3=x1+x2 (rs1=5, rs2=7), no forwards -> next cycle alu_a_o=5, alu_b_o=7, ex_rd_o=3, ex_reg_write_o=1.
- rs1=x3 with exm_rd_i=3/exm_result_i=0x11 and wb_rd_i=3/wb_result_i=0x22 -> alu_a_o=0x11. Drop exm_reg_write_i -> 0x22. Set rd=0 -> raw data.
- lw x4 in EX, ID reads x4 -> load_use_o=1. flush_i for one cycle -> ex_valid_o=0, ex_mem_read_o=0, load_use_o=0.
- stall_i 3 cycles while ID changes -> outputs frozen. stall_i+flush_i same cycle -> bubble.
- jal: src_a=pc 0x100, src_b=const 4 -> alu_b_o=4, alu_a_o=0x100. lui: src_b=imm 0x12345000, ctrl=PASSB -> alu_b_o=0x12345000.
